imem_fetch_port: RTL

//  Parametrised instruction memory with a valid/ready fetch port, replacing the single-cycle

---
 rtl/imem_fetch_port.sv | 96 +++++++++
 1 files changed

// File: rtl/imem_fetch_port.sv
// Instruction memory with valid/ready fetch port, program-load write port, fault flag and fetch counter.
// Latency: exactly one cycle from an accepted request to rsp_valid; back-to-back accepts give one response per cycle.
// Backpressure: rsp_* held while rsp_valid && !rsp_ready; req_ready drops while stalled or while ld_en is high.
// Build option: define IMEM_BYTE_ADDR_EN to treat req_pc as a byte address with a word-alignment check.
module imem_fetch_port #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 32,
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_pc,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_instr,
  output logic [ADDR_W-1:0] rsp_pc,
  output logic              rsp_fault,
  input  logic              ld_en,
  input  logic [IDX_W-1:0]  ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic [31:0]       fetch_cnt
);

  // Instruction storage; deliberately not reset so a loaded program survives rst.
  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] word_idx;
  logic              misaligned;
  logic              out_of_range;
  logic              req_fault;
  logic              accept;
  logic              ld_in_range;

  // Translate req_pc into a word index and an alignment flag for the selected addressing mode.
`ifdef IMEM_BYTE_ADDR_EN
  always_comb begin
    word_idx   = req_pc >> 2;
    misaligned = |req_pc[1:0];
  end
`else
  always_comb begin
    word_idx   = req_pc;
    misaligned = 1'b0;
  end
`endif

  // Range check covers every upper bit of the index, not just the IDX_W bits used for lookup.
  always_comb begin
    out_of_range = (word_idx >= ADDR_W'(DEPTH));
    req_fault    = out_of_range || misaligned;
    ld_in_range  = ({1'b0, ld_addr} < (IDX_W + 1)'(DEPTH));
  end

  // A load owns the cycle; otherwise a request is taken whenever the output slot is free or draining.
  always_comb begin
    req_ready = !ld_en && (!rsp_valid || rsp_ready);
    accept    = req_valid && req_ready;
  end

  // Program-load write port; independent of rst so a load issued during reset still lands.
  always_ff @(posedge clk) begin
    if (ld_en && ld_in_range) begin
      mem[ld_addr] <= ld_data;
    end
  end

  // Response register: capture on accept, hold while stalled, clear valid on a drain.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_instr <= '0;
      rsp_pc    <= '0;
      rsp_fault <= 1'b0;
    end else if (accept) begin
      rsp_valid <= 1'b1;
      rsp_pc    <= req_pc;
      rsp_fault <= req_fault;
      rsp_instr <= req_fault ? '0 : mem[word_idx[IDX_W-1:0]];
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

  // Count accepted fetches, faulting ones included; wraps naturally at 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt <= '0;
    end else if (accept) begin
      fetch_cnt <= fetch_cnt + 32'd1;
    end
  end

endmodule
